// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, limits and lane/extension helpers for the data-memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int MAX_READ_LATENCY = 4;

    // What a load needs, after the RAM word is read, to produce its result.
    typedef struct packed {
        size_e      size;
        logic       sign;
        logic [1:0] off;
    } ld_meta_t;

    function automatic logic [3:0] lane_en(input size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input ld_meta_t m);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {m.off, 3'b000};
        case (m.size)
            SIZE_BYTE: res = {{24{m.sign & sh[7]}}, sh[7:0]};
            SIZE_HALF: res = {{16{m.sign & sh[15]}}, sh[15:0]};
            default:   res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus between the MEM stage and the data-memory controller
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, misalign_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, misalign_err
    );
endinterface

// File: rtl/dmem_ram_bank.sv
// rtl/dmem_ram_bank.sv - word RAM with byte-enable write port and a READ_LATENCY-stage read pipeline
module dmem_ram_bank #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    input  logic [READ_LATENCY-1:0]        adv_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_q  [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Stages only advance when a load occupies them, so the last one holds the previous response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            if (adv_i[0]) begin
                rd_q[0] <= mem_q[idx_i];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (adv_i[i]) begin
                    rd_q[i] <= rd_q[i-1];
                end
            end
        end
    end

    assign rdata_o = rd_q[READ_LATENCY-1];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: handshake, load counter, alignment and response path
// Optional misalignment detection is enabled by defining DMEM_MISALIGN_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT   = (READ_LATENCY < 1) ? 1 :
                           (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    state_e         state_q, state_d;
    logic [1:0]     busy_cnt_q, busy_cnt_d;
    logic [LAT-1:0] vld_q;
    ld_meta_t       meta_q [LAT];
    logic [LAT-1:0] adv;

    size_e       size_n;
    logic [1:0]  off;
    logic        misalign;
    logic        ready;
    logic        accept;
    logic        do_load;
    logic        do_store;
    logic [31:0] wdata_rep;
    logic [3:0]  be;
    logic [31:0] bank_rdata;
    logic        unused_addr;

    always_comb begin
        size_n = (bus.req_size == 2'b11) ? SIZE_WORD : size_e'(bus.req_size);
`ifdef DMEM_MISALIGN_EN
        misalign = ((size_n == SIZE_HALF) && bus.req_addr[0]) ||
                   ((size_n == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
        off      = bus.req_addr[1:0];
`else
        misalign = 1'b0;
        case (size_n)
            SIZE_HALF: off = {bus.req_addr[1], 1'b0};
            SIZE_WORD: off = 2'b00;
            default:   off = bus.req_addr[1:0];
        endcase
`endif
    end

    assign accept   = bus.req_valid && ready;
    assign do_store = accept && bus.req_write && !misalign;
    assign do_load  = accept && !bus.req_write && !misalign;
    assign be       = lane_en(size_n, off);

    always_comb begin
        case (size_n)
            SIZE_BYTE: wdata_rep = {4{bus.req_wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{bus.req_wdata[15:0]}};
            default:   wdata_rep = bus.req_wdata;
        endcase
    end

    assign unused_addr = ^bus.req_addr[31:IDX_W+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = (busy_cnt_q != 2'd0) ? busy_cnt_q - 2'd1 : 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (do_load) begin
                    busy_cnt_d = 2'(LAT - 1);
                    if (LAT > 1) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                if (busy_cnt_q == 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
    end

    // Valid and load attributes travel alongside the RAM read stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= do_load;
            if (do_load) begin
                meta_q[0] <= '{size: size_n, sign: bus.req_signed, off: off};
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    meta_q[i] <= meta_q[i-1];
                end
            end
        end
    end

    always_comb begin
        adv[0] = do_load;
        for (int i = 1; i < LAT; i++) begin
            adv[i] = vld_q[i-1];
        end
    end

    dmem_ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .READ_LATENCY(LAT)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we_i   (do_store),
        .be_i   (be),
        .idx_i  (bus.req_addr[IDX_W+1:2]),
        .wdata_i(wdata_rep),
        .adv_i  (adv),
        .rdata_o(bank_rdata)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = vld_q[LAT-1];
    assign bus.rsp_rdata = load_ext(bank_rdata, meta_q[LAT-1]);

`ifdef DMEM_MISALIGN_EN
    logic misalign_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= accept && misalign;
        end
    end

    assign bus.misalign_err = misalign_err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule
